// File: rtl/uart_rx_8n1.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_8n1
// Purpose  : 8N1 UART receiver on the system clock with valid/ready byte output.
// Revision : 1.0  initial release
// ============================================================================
module uart_rx_8n1 #(
  parameter int CLKS_PER_BIT = 104,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int               CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t           state;
  logic             sync1;
  logic             sync2;
  logic             rxs;
  logic [CNT_W-1:0] cyc_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic             hs;

  assign rxs     = sync2;
  assign hs      = rx_valid & rx_ready;
  assign rx_busy = (state != S_IDLE);

  // Synchronizer resets to the idle level so release never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= uart_rx;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cyc_cnt   <= '0;
      bit_idx   <= 3'd0;
      shift_reg <= 8'h00;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (hs) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (!rxs) begin
            state   <= S_START;
            cyc_cnt <= '0;
          end
        end

        S_START: begin
          if (cyc_cnt == HALF_LAST) begin
            cyc_cnt <= '0;
            bit_idx <= 3'd0;
            state   <= rxs ? S_IDLE : S_DATA;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (cyc_cnt == BIT_LAST) begin
            cyc_cnt   <= '0;
            shift_reg <= {rxs, shift_reg[7:1]};
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end

        S_STOP: begin
          if (cyc_cnt == BIT_LAST) begin
            cyc_cnt <= '0;
            if (rxs) begin
              state <= S_IDLE;
              // A byte still pending without a handshake wins; the new one is lost.
              if (!rx_valid || hs) begin
                rx_data  <= shift_reg;
                rx_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= S_BREAK;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end

        S_BREAK: begin
          if (rxs) begin
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_8n1.sv
`default_nettype none
// Testbench for uart_rx_8n1: directed scenarios plus randomized frames,
// compared every cycle against a frame-level model of the receiver.
module tb_uart_rx_8n1;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
  localparam int LAT  = 2 + HALF + 9 * CPB + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       uart_rx;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun;

  uart_rx_8n1 #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .uart_rx  (uart_rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .rx_busy  (rx_busy),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         start;
    int         due;
    logic [7:0] data;
    bit         stop_ok;
  } frame_t;

  frame_t     fq[$];
  frame_t     mf;
  int         cyc = 0;
  bit         rdy_s = 1'b0;
  bit         rdy_rand = 1'b0;
  int         checks = 0;
  int         passes = 0;

  bit         m_valid, m_ovr, m_ferr, m_hs;
  logic [7:0] m_data;

  bit         prev_v = 1'b0;
  int         nrise = 0, ferr_cnt = 0, busy_cnt = 0;
  int         last_rise = 0, last_start = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rdy_s <= rx_ready;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act >= lo && act <= hi) passes++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endtask

  // Frame-level model: each frame's stop sample lands LAT cycles after its start edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0; m_data = 8'h00;
      fq.delete();
    end else begin
      m_hs   = m_valid && rdy_s;
      m_ferr = 1'b0;
      if (m_hs) begin
        m_valid = 1'b0;
        m_ovr   = 1'b0;
      end
      if (fq.size() > 0 && fq[0].due <= cyc) begin
        mf = fq.pop_front();
        if (!mf.stop_ok) m_ferr = 1'b1;
        else if (!m_valid) begin
          m_valid = 1'b1;
          m_data  = mf.data;
        end else m_ovr = 1'b1;
      end
      if (fq.size() > 0 && cyc >= fq[0].start + 3 && cyc < fq[0].due)
        check("busy_in_frame", {31'd0, rx_busy}, 32'd1);
    end
    check("outputs", {21'd0, rx_valid, frame_err, overrun, rx_data},
                     {21'd0, m_valid, m_ferr, m_ovr, m_data});
  end

  always @(negedge clk) begin
    if (rx_valid && !prev_v) begin
      nrise++;
      last_rise = cyc;
    end
    prev_v = rx_valid;
    if (frame_err) ferr_cnt++;
    if (rx_busy) busy_cnt++;
    if (rdy_rand) rx_ready = ($urandom_range(0, 3) == 0);
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    if (n > 0) #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_bit, input int extra_low,
                            input int abort_slot);
    frame_t     f;
    logic [9:0] bits;
    bits = {stop_bit, d, 1'b0};
    @(posedge clk); #1;
    f.start = cyc; f.due = cyc + LAT; f.data = d; f.stop_ok = stop_bit;
    fq.push_back(f);
    last_start = cyc;
    for (int s = 0; s < 10; s++) begin
      uart_rx = bits[s];
      if (s == abort_slot) begin
        repeat (HALF) @(posedge clk);
        #1;
        rst_n   = 1'b0;
        uart_rx = 1'b1;
        return;
      end
      repeat (CPB) @(posedge clk);
      #1;
    end
    if (!stop_bit) idle(extra_low);
    uart_rx = 1'b1;
  endtask

  task automatic glitch(input int len);
    @(posedge clk); #1;
    uart_rx = 1'b0;
    idle(len);
    uart_rx = 1'b1;
  endtask

  task automatic wait_valid(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(negedge clk);
      if (rx_valid) ok = 1'b1;
    end
  endtask

  logic [7:0] got[3];
  bit         ok_w[3];
  int         v0, f0, b0, gap;
  logic [7:0] rd;
  bit         bad;

  initial begin
    rst_n = 1'b0; uart_rx = 1'b1; rx_ready = 1'b0;
    idle(3);
    check("reset_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_data", {24'd0, rx_data}, 32'd0);
    check("reset_flags", {29'd0, frame_err, overrun, rx_busy}, 32'd0);
    rst_n = 1'b1;
    idle(5);

    // 0xA5 with the consumer always ready
    @(negedge clk) rx_ready = 1'b1;
    v0 = nrise; f0 = ferr_cnt;
    send_frame(8'hA5, 1'b1, 0, -1);
    idle(4);
    check_rng("a5_latency", last_rise - last_start, LAT - 1, LAT + 1);
    check("a5_data", {24'd0, rx_data}, 32'h0000_00A5);
    check("a5_count", nrise - v0, 32'd1);
    check("a5_ferr", ferr_cnt - f0, 32'd0);
    check("a5_overrun", {31'd0, overrun}, 32'd0);

    // Back-to-back frames, consumer pulses ready after each byte
    @(negedge clk) rx_ready = 1'b0;
    fork
      begin
        send_frame(8'h00, 1'b1, 0, -1);
        send_frame(8'hFF, 1'b1, 0, -1);
        send_frame(8'h3C, 1'b1, 0, -1);
      end
      begin
        for (int i = 0; i < 3; i++) begin
          wait_valid(25 * CPB, ok_w[i]);
          got[i] = rx_data;
          rx_ready = 1'b1;
          @(negedge clk) rx_ready = 1'b0;
        end
      end
    join
    idle(4);
    check("b2b_seen", {29'd0, ok_w[0], ok_w[1], ok_w[2]}, 32'd7);
    check("b2b_byte0", {24'd0, got[0]}, 32'h00);
    check("b2b_byte1", {24'd0, got[1]}, 32'hFF);
    check("b2b_byte2", {24'd0, got[2]}, 32'h3C);
    check("b2b_overrun", {31'd0, overrun}, 32'd0);

    // Overrun: two bytes, nobody accepting
    send_frame(8'h11, 1'b1, 0, -1);
    send_frame(8'h22, 1'b1, 0, -1);
    idle(2);
    check("ovr_valid", {31'd0, rx_valid}, 32'd1);
    check("ovr_data", {24'd0, rx_data}, 32'h11);
    check("ovr_flag", {31'd0, overrun}, 32'd1);
    @(negedge clk) rx_ready = 1'b1;
    @(negedge clk) rx_ready = 1'b0;
    check("ovr_hs_valid", {31'd0, rx_valid}, 32'd0);
    check("ovr_hs_flag", {31'd0, overrun}, 32'd0);

    // Short glitch on an idle line
    b0 = busy_cnt; v0 = nrise; f0 = ferr_cnt;
    glitch(4);
    idle(HALF + 10);
    check("glitch_busy_cycles", busy_cnt - b0, HALF);
    check("glitch_no_valid", nrise - v0, 32'd0);
    check("glitch_no_ferr", ferr_cnt - f0, 32'd0);

    // Bad stop bit followed by a long break, then a good frame
    @(negedge clk) rx_ready = 1'b1;
    v0 = nrise; f0 = ferr_cnt;
    send_frame(8'h55, 1'b0, 40 * CPB, -1);
    idle(CPB);
    check("break_ferr_once", ferr_cnt - f0, 32'd1);
    check("break_no_valid", nrise - v0, 32'd0);
    send_frame(8'h81, 1'b1, 0, -1);
    idle(4);
    check("after_break_data", {24'd0, rx_data}, 32'h81);
    check("after_break_count", nrise - v0, 32'd1);

    // Reset in the middle of data bit 4
    send_frame(8'hC3, 1'b1, 0, 5);
    #1;
    check("midreset_data", {24'd0, rx_data}, 32'd0);
    check("midreset_flags", {28'd0, rx_valid, frame_err, overrun, rx_busy}, 32'd0);
    idle(3);
    rst_n = 1'b1;
    idle(CPB);
    v0 = nrise;
    send_frame(8'h7E, 1'b1, 0, -1);
    idle(4);
    check("post_reset_count", nrise - v0, 32'd1);
    check("post_reset_data", {24'd0, rx_data}, 32'h7E);

    // Randomized traffic with a random consumer
    rdy_rand = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        glitch($urandom_range(1, HALF - 1));
        idle(HALF + 4);
      end else begin
        rd  = 8'($urandom);
        bad = ($urandom_range(0, 7) == 0);
        send_frame(rd, !bad, bad ? $urandom_range(0, 3 * CPB) : 0, -1);
        gap = $urandom_range(0, 2 * CPB);
        if (bad && gap < 4) gap = 4;
        idle(gap);
      end
    end
    rdy_rand = 1'b0;
    @(negedge clk) rx_ready = 1'b1;
    idle(12 * CPB);
    check("queue_drained", fq.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_8n1.md
Name: uart_rx_8n1

Overview:
- UART 8N1 receiver: the receive-side counterpart of the existing 8N1 transmitter path.
- Runs directly on the system clock with an internal bit-period counter; it does not need the baud clock generator.
- Samples the asynchronous serial input and reassembles LSB-first bytes.
- Presents each byte on a valid/ready handshake, with framing-error and overrun reporting, for loopback and command input on the board.

Parameters:
- CLKS_PER_BIT, 104, system clock cycles per bit (12 MHz / 115200); legal range 8..65535.
- HALF_BIT, CLKS_PER_BIT/2, cycles from the detected start edge to the start-bit mid-sample.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- uart_rx  input  1  serial line; idles high; asynchronous to clk.
- rx_data  output  8  last accepted byte; stable while rx_valid=1.
- rx_valid  output  1  byte available; held until the handshake.
- rx_ready  input  1  consumer accepts; handshake = rx_valid & rx_ready on a rising clk edge.
- rx_busy  output  1  high in every state except IDLE.
- frame_err  output  1  one-cycle pulse when the stop-bit sample is 0.
- overrun  output  1  sticky; set when a good byte completes while an unaccepted byte is pending.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - rx_data=0, rx_valid=0, frame_err=0, overrun=0, rx_busy=0.
  - State=IDLE; all counters 0.
  - Both synchronizer flops reset to 1, so no false start is detected on release.
- Input conditioning: uart_rx passes through 2 flops to give rxs; all decisions use rxs only.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- Counters: cyc_cnt, width clog2(CLKS_PER_BIT); bit_idx, 3 bits.
- IDLE:
  - rxs==0 -> START, cyc_cnt=0.
- START:
  - cyc_cnt increments each cycle.
  - At cyc_cnt==HALF_BIT-1, if rxs==0 -> DATA, cyc_cnt=0, bit_idx=0.
  - At cyc_cnt==HALF_BIT-1, if rxs==1 -> IDLE (glitch rejected; no outputs change).
- DATA:
  - At cyc_cnt==CLKS_PER_BIT-1, shift rxs in LSB-first (shift_reg = {rxs, shift_reg[7:1]}) and reset cyc_cnt to 0.
  - After the sample with bit_idx==7 -> STOP; otherwise bit_idx+1.
  - Samples fall at the middle of each bit.
- STOP, at cyc_cnt==CLKS_PER_BIT-1:
  - rxs==1 -> deliver byte, -> IDLE.
  - rxs==0 -> frame_err=1 for exactly one cycle, byte discarded, -> BREAK.
- BREAK:
  - Waits for rxs==1, then -> IDLE.
  - A held-low line therefore produces exactly one frame_err, not repeated frames.
- Deliver rule, applied in the same cycle as the stop sample:
  - If rx_valid==0, or the handshake occurs that cycle: rx_data=shift_reg, rx_valid=1.
  - Otherwise: rx_data and rx_valid are unchanged, the new byte is dropped, overrun=1.
- Handshake:
  - rx_valid&rx_ready with no simultaneous delivery -> rx_valid=0 next cycle.
  - overrun clears on any handshake cycle.
  - Delivery and handshake in the same cycle: valid stays 1, new data is loaded, overrun clears.
- rx_ready while rx_valid=0 is ignored.
- Latency:
  - rx_valid rises 2 + HALF_BIT + 9*CLKS_PER_BIT + 1 cycles (±1) after the uart_rx falling edge.
  - The next start edge is accepted from the first IDLE cycle, which allows back-to-back frames with a one-bit stop.
- Reset mid-frame: immediately returns to IDLE with reset values; the partial byte is discarded.
- Line events during START/DATA/STOP are ignored except at the sample points.

Test Plan (CLKS_PER_BIT=16 in simulation):
- Send 0xA5, stop=1, rx_ready held 1 -> one rx_valid with rx_data=0xA5; rising 2+8+144+1 (±1) cycles after the start edge; frame_err and overrun stay 0.
- Send 0x00, 0xFF, 0x3C back-to-back, with rx_ready pulsed after each valid -> three deliveries in order, no overrun.
- Send 0x11 then 0x22 with rx_ready=0 throughout -> rx_data stays 0x11 and overrun=1 after the second stop bit. Then rx_ready=1 for one cycle -> rx_valid=0, overrun=0.
- 4-cycle low glitch on an idle line -> FSM returns to IDLE at the mid-sample; no rx_valid, no frame_err, rx_busy high for HALF_BIT cycles only.
- Frame 0x55 with stop bit driven 0, line held low 40 bit-times, then released -> exactly one frame_err pulse, no rx_valid. A following 0x81 is received correctly.
- Assert rst_n=0 during bit 4 of 0xC3, release, then send 0x7E -> outputs reset immediately; only 0x7E is delivered.
